// File: rtl/decodificador_corriente_rampa.sv
// Turns a current setting into a PWM compare limit that ramps toward its target a few counts per PWM period.
// Outputs are registered with 1-clock latency after a qualifying fin_periodo; no backpressure (the PWM period is the pacing).
module decodificador_corriente_rampa #(
  parameter int N_BITS_I      = 5,
  parameter int N_BITS_CUENTA = 10,
  parameter int PASO          = 32,
  parameter int PASO_RAMPA    = 8,
  parameter int DIV_RAMPA     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     habilitar,
  input  logic [N_BITS_I-1:0]      contador_I,
  input  logic                     fin_periodo,
  output logic [N_BITS_CUENTA-1:0] cuenta_max,
  output logic                     rampa_activa,
  output logic                     objetivo_alcanzado
);

  localparam int CW = N_BITS_CUENTA;
  localparam int PW = N_BITS_I + 32;
  localparam logic [PW-1:0] PASO_EXT = PW'(PASO);
  localparam logic [PW-1:0] MAX_EXT  = PW'({CW{1'b1}});
  localparam logic [31:0]   PASO_R32 = 32'(PASO_RAMPA);
  localparam logic [CW-1:0] PASO_R   = CW'(PASO_RAMPA);
  localparam logic [7:0]    DIV_LAST = 8'(DIV_RAMPA - 1);

  typedef enum logic [1:0] {APAGADO, SUBIR, BAJAR, ESTABLE} estado_t;

  estado_t       estado, estado_sig;
  logic [7:0]    div_cnt, div_sig;
  logic [CW-1:0] cuenta_sig;
  logic [PW-1:0] producto;
  logic [CW-1:0] objetivo;
  logic [CW-1:0] diferencia;
  logic [CW-1:0] delta;
  logic          evento;
  logic          paso_rampa;

  always_comb begin
    // Full-width product so large settings saturate instead of wrapping.
    producto   = PW'(contador_I) * PASO_EXT;
    objetivo   = (producto > MAX_EXT) ? MAX_EXT[CW-1:0] : producto[CW-1:0];
    evento     = habilitar && fin_periodo;
    paso_rampa = evento && (div_cnt == DIV_LAST);

    diferencia = (cuenta_max < objetivo) ? (objetivo - cuenta_max) : (cuenta_max - objetivo);
    delta      = (32'(diferencia) <= PASO_R32) ? diferencia : PASO_R;

    estado_sig = estado;
    cuenta_sig = cuenta_max;
    div_sig    = div_cnt;

    if (!habilitar) begin
      estado_sig = APAGADO;
      cuenta_sig = '0;
      div_sig    = '0;
    end else if (evento) begin
      div_sig = paso_rampa ? 8'd0 : div_cnt + 8'd1;
      if (paso_rampa) begin
        if (cuenta_max < objetivo)
          cuenta_sig = cuenta_max + delta;
        else if (cuenta_max > objetivo)
          cuenta_sig = cuenta_max - delta;
      end
      if (cuenta_sig == objetivo)
        estado_sig = ESTABLE;
      else if (cuenta_sig < objetivo)
        estado_sig = SUBIR;
      else
        estado_sig = BAJAR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado             <= APAGADO;
      cuenta_max         <= '0;
      div_cnt            <= '0;
      rampa_activa       <= 1'b0;
      objetivo_alcanzado <= 1'b0;
    end else begin
      estado             <= estado_sig;
      cuenta_max         <= cuenta_sig;
      div_cnt            <= div_sig;
      rampa_activa       <= (estado_sig == SUBIR) || (estado_sig == BAJAR);
      objetivo_alcanzado <= (estado_sig == ESTABLE) && habilitar;
    end
  end

endmodule

// File: tb/tb_decodificador_corriente_rampa.sv
// Directed table of per-clock vectors on the default instance, plus hand sequences for saturation and small ramp steps.
module tb_decodificador_corriente_rampa;

  typedef struct {
    int         reps;
    logic       rst;
    logic       hab;
    logic [4:0] ci;
    logic       fin;
    int         c;
    logic       ra;
    logic       oa;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       habilitar = 1'b0;
  logic [4:0] contador_I = '0;
  logic       fin_periodo = 1'b0;
  logic [9:0] c0, c1, c2;
  logic       ra0, ra1, ra2, oa0, oa1, oa2;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t tabla[$];

  always #5 clk = ~clk;

  decodificador_corriente_rampa dut0 (
    .clk(clk), .reset(reset), .habilitar(habilitar), .contador_I(contador_I),
    .fin_periodo(fin_periodo), .cuenta_max(c0), .rampa_activa(ra0), .objetivo_alcanzado(oa0));

  decodificador_corriente_rampa #(.PASO(40)) dut1 (
    .clk(clk), .reset(reset), .habilitar(habilitar), .contador_I(contador_I),
    .fin_periodo(fin_periodo), .cuenta_max(c1), .rampa_activa(ra1), .objetivo_alcanzado(oa1));

  decodificador_corriente_rampa #(.PASO_RAMPA(12)) dut2 (
    .clk(clk), .reset(reset), .habilitar(habilitar), .contador_I(contador_I),
    .fin_periodo(fin_periodo), .cuenta_max(c2), .rampa_activa(ra2), .objetivo_alcanzado(oa2));

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ciclo(input logic rst, input logic hab, input int ci, input logic fin,
                                input int reps, input int c, input logic ra, input logic oa);
    vec_t v;
    v.reps = reps; v.rst = rst; v.hab = hab; v.ci = 5'(ci); v.fin = fin;
    v.c = c; v.ra = ra; v.oa = oa;
    tabla.push_back(v);
  endfunction

  // One fin_periodo pulse followed by 9 quiet clocks where nothing may change.
  function automatic void pulso(input int ci, input int c, input logic ra, input logic oa);
    ciclo(1'b0, 1'b1, ci, 1'b1, 1, c, ra, oa);
    ciclo(1'b0, 1'b1, ci, 1'b0, 9, c, ra, oa);
  endfunction

  initial begin
    int k;
    int exp_c;
    int exp2[7] = '{0, 12, 12, 24, 24, 32, 32};

    ciclo(1'b1, 1'b0, 0, 1'b0, 2, 0, 0, 0);
    ciclo(1'b0, 1'b1, 1, 1'b0, 3, 0, 0, 0);
    pulso(1, 0, 1, 0);  pulso(1, 8, 1, 0);  pulso(1, 8, 1, 0);  pulso(1, 16, 1, 0);
    pulso(1, 16, 1, 0); pulso(1, 24, 1, 0); pulso(1, 24, 1, 0); pulso(1, 32, 0, 1);
    ciclo(1'b0, 1'b1, 3, 1'b0, 5, 32, 0, 1);
    ciclo(1'b0, 1'b1, 1, 1'b0, 4, 32, 0, 1);
    pulso(0, 32, 1, 0); pulso(0, 24, 1, 0); pulso(0, 24, 1, 0); pulso(0, 16, 1, 0);
    pulso(0, 16, 1, 0); pulso(0, 8, 1, 0);  pulso(0, 8, 1, 0);  pulso(0, 0, 0, 1);
    pulso(1, 0, 1, 0);  pulso(1, 8, 1, 0);  pulso(1, 8, 1, 0);  pulso(1, 16, 1, 0);
    pulso(1, 16, 1, 0);
    ciclo(1'b0, 1'b0, 1, 1'b1, 1, 0, 0, 0);
    ciclo(1'b0, 1'b1, 1, 1'b0, 3, 0, 0, 0);
    pulso(1, 0, 1, 0);  pulso(1, 8, 1, 0);
    pulso(2, 8, 1, 0);  pulso(2, 16, 1, 0); pulso(2, 16, 1, 0); pulso(2, 24, 1, 0);
    pulso(2, 24, 1, 0); pulso(2, 32, 1, 0); pulso(2, 32, 1, 0); pulso(2, 40, 1, 0);
    ciclo(1'b1, 1'b1, 2, 1'b1, 1, 0, 0, 0);
    ciclo(1'b0, 1'b1, 2, 1'b0, 3, 0, 0, 0);
    pulso(2, 0, 1, 0);  pulso(2, 8, 1, 0);

    k = 0;
    foreach (tabla[i]) begin
      for (int r = 0; r < tabla[i].reps; r++) begin
        reset       = tabla[i].rst;
        habilitar   = tabla[i].hab;
        contador_I  = tabla[i].ci;
        fin_periodo = tabla[i].fin;
        tick();
        chk("cuenta_max", k, int'(c0), tabla[i].c);
        chk("rampa_activa", k, int'(ra0), int'(tabla[i].ra));
        chk("objetivo_alcanzado", k, int'(oa0), int'(tabla[i].oa));
        k++;
      end
    end

    // Saturated target: 31*40 = 1240 clips to 1023, reached on pulse 256.
    reset = 1'b1; habilitar = 1'b1; contador_I = 5'd31; fin_periodo = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 300; i++) begin
      fin_periodo = 1'b1;
      tick();
      exp_c = (8 * (i / 2) > 1023) ? 1023 : 8 * (i / 2);
      chk("sat_cuenta", i, int'(c1), exp_c);
      fin_periodo = 1'b0;
      tick();
    end
    chk("sat_oa", 0, int'(oa1), 1);
    chk("sat_ra", 0, int'(ra1), 0);

    // Step of 12 toward 32 must stop at 32 (last step only 8).
    reset = 1'b1; contador_I = 5'd1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      fin_periodo = 1'b1;
      tick();
      chk("paso12_cuenta", i, int'(c2), exp2[i]);
      fin_periodo = 1'b0;
      tick();
      tick();
    end
    chk("paso12_oa", 0, int'(oa2), 1);
    chk("paso12_ra", 0, int'(ra2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset && ra0 && oa0) begin
      n_chk++;
      $display("FAIL flags_exclusive: rampa_activa=1 and objetivo_alcanzado=1, expected not both");
    end
  end

endmodule
